// File: rtl/life_pkg.sv
// Shared types and helpers for the 8x8 Game-of-Life engine.
package life_pkg;

    localparam int GRID_DIM = 8;

    typedef logic [63:0] grid_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } life_state_t;

    // Row 0 occupies bits 7:0; column is the bit within the row byte.
    function automatic logic [5:0] idx(input int row, input int col);
        return 6'(row * GRID_DIM + col);
    endfunction

endpackage

// File: rtl/life_next_gen.sv
// Combinational B3/S23 rule: one neighbour counter per cell, optional torus wrap.
module life_next_gen
    import life_pkg::*;
#(
    parameter int WRAP = 0
) (
    input  grid_t cur_i,
    output grid_t nxt_o
);

    // Out-of-range neighbours read as dead unless the grid wraps.
    function automatic logic cell_at(input grid_t g, input int r, input int c);
        int rr;
        int cc;
        rr = r;
        cc = c;
        if (WRAP != 0) begin
            rr = (r + GRID_DIM) % GRID_DIM;
            cc = (c + GRID_DIM) % GRID_DIM;
        end
        if (rr < 0 || rr >= GRID_DIM || cc < 0 || cc >= GRID_DIM)
            return 1'b0;
        return g[idx(rr, cc)];
    endfunction

    for (genvar R = 0; R < GRID_DIM; R++) begin : g_row
        for (genvar C = 0; C < GRID_DIM; C++) begin : g_col
            localparam logic [5:0] I = idx(R, C);
            logic [3:0] cnt;

            always_comb begin
                cnt = '0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        if (dr != 0 || dc != 0)
                            cnt = cnt + {3'b000, cell_at(cur_i, R + dr, C + dc)};
                    end
                end
            end

            assign nxt_o[I] = (cnt == 4'd3) || (cur_i[I] && cnt == 4'd2);
        end
    end

endmodule

// File: rtl/life_grid_engine.sv
// Generation engine: holds the grid, divides the rate tick, halts on still-life or extinction.
module life_grid_engine
    import life_pkg::*;
#(
    parameter int TICK_DIV = 4,
    parameter int GEN_W    = 16,
    parameter int WRAP     = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  grid_t            seed,
    input  logic             clear,
    input  logic             pause,
    input  logic             step,
    output grid_t            grid,
    output logic [GEN_W-1:0] gen_count,
    output logic             running,
    output logic             stable,
    output logic             empty
);

    localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);

    life_state_t      state_q, state_d;
    grid_t            grid_q, grid_d;
    logic [GEN_W-1:0] gen_q, gen_d;
    logic             stable_q, stable_d;
    logic [15:0]      tick_q, tick_d;

    grid_t nxt;
    logic  in_run, tick, advance;

    life_next_gen #(.WRAP(WRAP)) u_next (
        .cur_i (grid_q),
        .nxt_o (nxt)
    );

    assign in_run  = (state_q == RUN);
    assign tick    = (tick_q == TICK_LAST) && !pause;
    assign advance = in_run && (tick || (pause && step));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            grid_q   <= '0;
            gen_q    <= '0;
            stable_q <= 1'b0;
            tick_q   <= '0;
        end else begin
            state_q  <= state_d;
            grid_q   <= grid_d;
            gen_q    <= gen_d;
            stable_q <= stable_d;
            tick_q   <= tick_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        grid_d   = grid_q;
        gen_d    = gen_q;
        stable_d = stable_q;
        tick_d   = tick_q;

        if (clear) begin
            state_d  = IDLE;
            grid_d   = '0;
            gen_d    = '0;
            stable_d = 1'b0;
            tick_d   = '0;
        end else if (load) begin
            state_d  = RUN;
            grid_d   = seed;
            gen_d    = '0;
            stable_d = 1'b0;
            tick_d   = '0;
        end else if (in_run) begin
            if (!pause)
                tick_d = tick ? 16'd0 : tick_q + 16'd1;
            if (advance) begin
                // A still-life freezes the count; extinction still counts as a generation.
                if (nxt == grid_q) begin
                    stable_d = 1'b1;
                    state_d  = HALT;
                end else begin
                    grid_d = nxt;
                    gen_d  = (gen_q == '1) ? gen_q : gen_q + GEN_W'(1);
                    if (nxt == '0)
                        state_d = HALT;
                end
            end
        end
    end

    assign grid      = grid_q;
    assign gen_count = gen_q;
    assign running   = in_run;
    assign stable    = stable_q;
    assign empty     = (grid_q == '0);

endmodule

// File: tb/tb_life_grid_engine.sv
// Two engines (bounded/slow and torus/fast/narrow counter) checked every cycle against a behavioural model.
module tb_life_grid_engine;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load = 1'b0, clear = 1'b0, pause = 1'b0, step = 1'b0;
    logic [63:0] seed = '0;

    logic [63:0] a_grid, b_grid;
    logic [15:0] a_gen;
    logic [2:0]  b_gen;
    logic        a_run, a_stb, a_emp, b_run, b_stb, b_emp;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    life_grid_engine #(.TICK_DIV(4), .GEN_W(16), .WRAP(0)) u_a (
        .clk(clk), .reset(reset), .load(load), .seed(seed), .clear(clear),
        .pause(pause), .step(step), .grid(a_grid), .gen_count(a_gen),
        .running(a_run), .stable(a_stb), .empty(a_emp)
    );

    life_grid_engine #(.TICK_DIV(1), .GEN_W(3), .WRAP(1)) u_b (
        .clk(clk), .reset(reset), .load(load), .seed(seed), .clear(clear),
        .pause(pause), .step(step), .grid(b_grid), .gen_count(b_gen),
        .running(b_run), .stable(b_stb), .empty(b_emp)
    );

    // Model state: st 0 = idle, 1 = running, 2 = halted.
    typedef struct packed {
        logic [63:0] g;
        int          gen;
        bit          stb;
        int          st;
        int          tk;
    } mdl_t;

    mdl_t ma = '0, mb = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] life(input logic [63:0] g, input bit wr);
        logic [63:0] res = '0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                int n = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        int rr = r + dr;
                        int cc = c + dc;
                        if (dr == 0 && dc == 0) continue;
                        if (wr) begin
                            rr = (rr + 8) % 8;
                            cc = (cc + 8) % 8;
                        end
                        if (rr >= 0 && rr < 8 && cc >= 0 && cc < 8)
                            n += int'(g[6'(rr * 8 + cc)]);
                    end
                end
                res[6'(r * 8 + c)] = (n == 3) || (g[6'(r * 8 + c)] && n == 2);
            end
        end
        return res;
    endfunction

    function automatic mdl_t mstep(input mdl_t m, input int td, input bit wr, input int gmax);
        mdl_t        n = m;
        logic [63:0] nx;
        bit          tick;
        if (clear) begin
            n = '0;
        end else if (load) begin
            n = '0;
            n.g  = seed;
            n.st = 1;
        end else if (m.st == 1) begin
            tick = (m.tk == td - 1) && !pause;
            if (!pause) n.tk = tick ? 0 : m.tk + 1;
            if (tick || (pause && step)) begin
                nx = life(m.g, wr);
                if (nx == m.g) begin
                    n.stb = 1'b1;
                    n.st  = 2;
                end else begin
                    n.g = nx;
                    if (m.gen < gmax) n.gen = m.gen + 1;
                    if (nx == 0) n.st = 2;
                end
            end
        end
        return n;
    endfunction

    task automatic cmp_all();
        chk("a_grid", a_grid, ma.g);
        chk("a_gen", 64'(a_gen), 64'(ma.gen));
        chk("a_running", 64'(a_run), 64'(ma.st == 1));
        chk("a_stable", 64'(a_stb), 64'(ma.stb));
        chk("a_empty", 64'(a_emp), 64'(ma.g == 0));
        chk("b_grid", b_grid, mb.g);
        chk("b_gen", 64'(b_gen), 64'(mb.gen));
        chk("b_running", 64'(b_run), 64'(mb.st == 1));
        chk("b_stable", 64'(b_stb), 64'(mb.stb));
        chk("b_empty", 64'(b_emp), 64'(mb.g == 0));
    endtask

    task automatic cyc();
        @(posedge clk);
        if (reset) begin
            ma = '0;
            mb = '0;
        end else begin
            ma = mstep(ma, 4, 1'b0, 65535);
            mb = mstep(mb, 1, 1'b1, 7);
        end
        #1;
        cmp_all();
    endtask

    task automatic do_load(input logic [63:0] s);
        seed = s;
        load = 1'b1;
        cyc();
        load = 1'b0;
    endtask

    localparam logic [63:0] BLINK_H = 64'h0000_0000_1C00_0000;
    localparam logic [63:0] BLINK_V = 64'h0000_0008_0808_0000;

    initial begin
        repeat (2) cyc();
        reset = 1'b0;
        repeat (10) cyc();
        chk("rst_grid", a_grid, 64'h0);
        chk("rst_gen", 64'(a_gen), 64'h0);
        chk("rst_running", 64'(a_run), 64'h0);
        chk("rst_stable", 64'(a_stb), 64'h0);
        chk("rst_empty", 64'(a_emp), 64'h1);

        // Blinker: period-2 oscillator, never halts
        do_load(BLINK_H);
        repeat (4) cyc();
        chk("blink_g1", a_grid, BLINK_V);
        chk("blink_gen1", 64'(a_gen), 64'd1);
        repeat (4) cyc();
        chk("blink_g2", a_grid, BLINK_H);
        chk("blink_gen2", 64'(a_gen), 64'd2);
        chk("blink_run", 64'(a_run), 64'h1);
        chk("b_gen_sat", 64'(b_gen), 64'd7);

        // Block: still-life halts with gen 0
        do_load(64'h0000_0000_0000_0303);
        repeat (4) cyc();
        chk("block_grid", a_grid, 64'h0303);
        chk("block_stable", 64'(a_stb), 64'h1);
        chk("block_gen", 64'(a_gen), 64'h0);
        chk("block_run", 64'(a_run), 64'h0);
        repeat (8) cyc();
        chk("block_hold", a_grid, 64'h0303);

        // Single cell dies: extinction counts one generation
        do_load(64'h1);
        repeat (4) cyc();
        chk("die_grid", a_grid, 64'h0);
        chk("die_empty", 64'(a_emp), 64'h1);
        chk("die_gen", 64'(a_gen), 64'd1);
        chk("die_stable", 64'(a_stb), 64'h0);
        chk("die_run", 64'(a_run), 64'h0);

        // Pause and step
        pause = 1'b1;
        do_load(BLINK_H);
        repeat (20) cyc();
        chk("pause_hold", a_grid, BLINK_H);
        step = 1'b1;
        cyc();
        step = 1'b0;
        chk("step_grid", a_grid, BLINK_V);
        chk("step_gen", 64'(a_gen), 64'd1);
        pause = 1'b0;
        step = 1'b1;
        cyc();
        step = 1'b0;
        repeat (3) cyc();

        // clear beats load
        seed = BLINK_H;
        load = 1'b1;
        clear = 1'b1;
        cyc();
        load = 1'b0;
        clear = 1'b0;
        chk("clr_ld_grid", a_grid, 64'h0);
        chk("clr_ld_run", 64'(a_run), 64'h0);

        // Asynchronous reset between edges
        do_load(BLINK_H);
        repeat (2) cyc();
        #3;
        reset = 1'b1;
        #1;
        chk("arst_grid", a_grid, 64'h0);
        chk("arst_run", 64'(a_run), 64'h0);
        chk("arst_empty", 64'(a_emp), 64'h1);
        chk("arst_b_grid", b_grid, 64'h0);
        cyc();
        reset = 1'b0;
        cyc();

        // Torus corner birth from three wrapped neighbours
        do_load((64'h1 << 0) | (64'h1 << 7) | (64'h1 << 56));
        cyc();
        chk("wrap_bit63", 64'(b_grid[63]), 64'h1);
        chk("nowrap_bit63", 64'(a_grid[63]), 64'h0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            clear = ($urandom_range(0, 59) == 0);
            load  = ($urandom_range(0, 24) == 0);
            if (load) seed = {$urandom, $urandom} & {$urandom, $urandom};
            if ($urandom_range(0, 19) == 0) pause = ~pause;
            step  = ($urandom_range(0, 3) == 0);
            cyc();
        end
        clear = 1'b0;
        load = 1'b0;
        step = 1'b0;
        pause = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
